parking_gate_arbiter: RTL and testbench

- Shares the single lot barrier gate between the entrance lane and the exit lane.
- Sequences a password check before every entry and tracks lot occupancy against capacity.
- Locks the entrance after repeated wrong passwords.
- Sits between the lane sensors/keypad and the barrier actuator, LEDs and occupancy display logic.

---
 rtl/parking_gate_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// Barrier gate arbiter: shares one gate between entrance and exit lanes, gates entry
// behind a two-digit password, tracks occupancy and locks the entrance after repeated failures.
module parking_gate_arbiter #(
    parameter int unsigned CAPACITY    = 8,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned OPEN_CYCLES = 16,
    parameter logic [1:0]  PASS_1      = 2'b01,
    parameter logic [1:0]  PASS_2      = 2'b10,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_entrance,
    input  logic             sensor_exit,
    input  logic [1:0]       password_1,
    input  logic [1:0]       password_2,
    input  logic             password_valid,
    input  logic             car_passed,
    output logic             gate_open,
    output logic             grant_entrance,
    output logic             grant_exit,
    output logic             GREEN_LED,
    output logic             RED_LED,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lockout
);

    localparam int unsigned TMax    = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned TimerW  = $clog2(TMax + 1);
    localparam int unsigned TriesW  = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitPass,
        StOpenIn,
        StOpenOut,
        StLocked
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    occ_q, occ_d;
    logic                lot_full_q, lot_full_d;
    logic [TriesW-1:0]   tries_q, tries_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    // 1: exit lane was served last, 0: entrance lane
    logic                last_exit_q, last_exit_d;

    logic                elig_ent, elig_exit;
    logic                pass_ok, open_timeout, lock_done;
    logic [TriesW-1:0]   tries_inc;

    always_comb begin
        elig_ent     = sensor_entrance && !lot_full_q;
        elig_exit    = sensor_exit && (occ_q != '0);
        pass_ok      = (password_1 == PASS_1) && (password_2 == PASS_2);
        open_timeout = (timer_q == TimerW'(OPEN_CYCLES - 1));
        lock_done    = (timer_q == TimerW'(LOCK_CYCLES - 1));
        tries_inc    = tries_q + TriesW'(1);
    end

    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        tries_d     = tries_q;
        timer_d     = timer_q;
        last_exit_d = last_exit_q;

        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                // On a tie the lane that was not served last wins
                if (elig_exit && (!elig_ent || !last_exit_q)) begin
                    state_d     = StOpenOut;
                    last_exit_d = 1'b1;
                end else if (elig_ent) begin
                    state_d     = StWaitPass;
                    last_exit_d = 1'b0;
                end
            end
            StWaitPass: begin
                timer_d = '0;
                if (password_valid) begin
                    if (pass_ok) begin
                        state_d = StOpenIn;
                        tries_d = '0;
                    end else begin
                        tries_d = tries_inc;
                        if (tries_inc == TriesW'(MAX_TRIES)) begin
                            state_d = StLocked;
                        end
                    end
                end else if (!sensor_entrance) begin
                    state_d = StIdle;
                end
            end
            StOpenIn, StOpenOut: begin
                timer_d = timer_q + TimerW'(1);
                if (car_passed) begin
                    state_d = StIdle;
                    timer_d = '0;
                    if (state_q == StOpenIn) begin
                        if (occ_q < CNT_W'(CAPACITY)) occ_d = occ_q + CNT_W'(1);
                    end else begin
                        if (occ_q != '0) occ_d = occ_q - CNT_W'(1);
                    end
                end else if (open_timeout) begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            end
            StLocked: begin
                timer_d = timer_q + TimerW'(1);
                if (lock_done) begin
                    state_d = StIdle;
                    timer_d = '0;
                    tries_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase

        lot_full_d = (occ_d == CNT_W'(CAPACITY));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            occ_q       <= '0;
            lot_full_q  <= (CAPACITY == 0);
            tries_q     <= '0;
            timer_q     <= '0;
            last_exit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            lot_full_q  <= lot_full_d;
            tries_q     <= tries_d;
            timer_q     <= timer_d;
            last_exit_q <= last_exit_d;
        end
    end

    always_comb begin
        gate_open      = 1'b0;
        grant_entrance = 1'b0;
        grant_exit     = 1'b0;
        GREEN_LED      = 1'b0;
        RED_LED        = 1'b0;
        lockout        = 1'b0;
        unique case (state_q)
            StIdle: ;
            StWaitPass: begin
                grant_entrance = 1'b1;
                RED_LED        = 1'b1;
            end
            StOpenIn: begin
                grant_entrance = 1'b1;
                gate_open      = 1'b1;
                GREEN_LED      = 1'b1;
            end
            StOpenOut: begin
                grant_exit = 1'b1;
                gate_open  = 1'b1;
                GREEN_LED  = 1'b1;
            end
            StLocked: begin
                lockout = 1'b1;
                RED_LED = 1'b1;
            end
            default: ;
        endcase
        occupancy = occ_q;
        lot_full  = lot_full_q;
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed scoreboard bench for parking_gate_arbiter: each step queues the expected
// output vector, clocks once and compares the registered outputs 1 ns after the edge.
module tb_parking_gate_arbiter;

    localparam int S_IDLE = 0, S_WAIT = 1, S_IN = 2, S_OUT = 3, S_LOCK = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_entrance, sensor_exit;
    logic [1:0] password_1, password_2;
    logic       password_valid, car_passed;
    logic       gate_open, grant_entrance, grant_exit, GREEN_LED, RED_LED, lot_full, lockout;
    logic [3:0] occupancy;

    parking_gate_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .password_1      (password_1),
        .password_2      (password_2),
        .password_valid  (password_valid),
        .car_passed      (car_passed),
        .gate_open       (gate_open),
        .grant_entrance  (grant_entrance),
        .grant_exit      (grant_exit),
        .GREEN_LED       (GREEN_LED),
        .RED_LED         (RED_LED),
        .occupancy       (occupancy),
        .lot_full        (lot_full),
        .lockout         (lockout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [10:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // {gate_open, grant_entrance, grant_exit, GREEN, RED, lockout, lot_full, occupancy}
    function automatic logic [10:0] exp_vec(int st, int occ);
        logic [6:0] f;
        case (st)
            S_WAIT:  f = 7'b0100100;
            S_IN:    f = 7'b1101000;
            S_OUT:   f = 7'b1011000;
            S_LOCK:  f = 7'b0000110;
            default: f = 7'b0000000;
        endcase
        f[0] = (occ == 8);
        return {f, 4'(occ)};
    endfunction

    task automatic tick(input string tag, input int st, input int occ);
        exp_t e, got;
        logic [10:0] obs;
        e.tag = tag;
        e.v   = exp_vec(st, occ);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs = {gate_open, grant_entrance, grant_exit, GREEN_LED, RED_LED, lockout, lot_full,
               occupancy};
        got = exp_q.pop_front();
        n_cmp++;
        assert (obs === got.v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.v);
        end
    endtask

    task automatic pw(input logic [1:0] a, input logic [1:0] b);
        password_valid = 1'b1;
        password_1     = a;
        password_2     = b;
    endtask

    initial begin
        reset = 1'b1;
        sensor_entrance = 0; sensor_exit = 0;
        password_1 = 0; password_2 = 0; password_valid = 0; car_passed = 0;
        tick("reset", S_IDLE, 0);
        reset = 1'b0;
        tick("idle_quiet", S_IDLE, 0);

        // Basic entry
        sensor_entrance = 1;
        tick("ent_wait", S_WAIT, 0);
        pw(2'b01, 2'b10);
        tick("ent_open", S_IN, 0);
        password_valid = 0; sensor_entrance = 0;
        car_passed = 1;
        tick("ent_pass", S_IDLE, 1);
        car_passed = 0;
        tick("ent_idle", S_IDLE, 1);

        // Lockout after three wrong passwords
        sensor_entrance = 1;
        tick("lk_wait", S_WAIT, 1);
        pw(2'b00, 2'b00);
        tick("lk_try1", S_WAIT, 1);
        tick("lk_try2", S_WAIT, 1);
        tick("lk_enter", S_LOCK, 1);
        pw(2'b01, 2'b10);
        for (int i = 1; i < 32; i++) begin
            tick($sformatf("lk_hold%0d", i), S_LOCK, 1);
            password_valid = 0;
        end
        tick("lk_release", S_IDLE, 1);
        tick("lk_rewait", S_WAIT, 1);
        pw(2'b11, 2'b00);
        tick("lk_tries_clr1", S_WAIT, 1);
        tick("lk_tries_clr2", S_WAIT, 1);
        pw(2'b01, 2'b10);
        tick("lk_after_open", S_IN, 1);
        password_valid = 0; car_passed = 1;
        tick("lk_after_pass", S_IDLE, 2);
        car_passed = 0; sensor_entrance = 0;

        // Round-robin tie: exit first, then entrance
        sensor_entrance = 1; sensor_exit = 1;
        tick("rr_exit", S_OUT, 2);
        car_passed = 1;
        tick("rr_exit_pass", S_IDLE, 1);
        car_passed = 0;
        tick("rr_ent", S_WAIT, 1);
        sensor_exit = 0;
        pw(2'b01, 2'b10);
        tick("rr_ent_open", S_IN, 1);
        password_valid = 0; car_passed = 1;
        tick("rr_ent_pass", S_IDLE, 2);
        car_passed = 0;

        // Fill the lot
        for (int n = 2; n < 8; n++) begin
            tick($sformatf("fill_wait%0d", n), S_WAIT, n);
            pw(2'b01, 2'b10);
            tick($sformatf("fill_open%0d", n), S_IN, n);
            password_valid = 0; car_passed = 1;
            tick($sformatf("fill_pass%0d", n), S_IDLE, n + 1);
            car_passed = 0;
        end
        tick("full_ignore1", S_IDLE, 8);
        tick("full_ignore2", S_IDLE, 8);
        sensor_exit = 1;
        tick("full_exit", S_OUT, 8);
        sensor_exit = 0; sensor_entrance = 0; car_passed = 1;
        tick("full_exit_pass", S_IDLE, 7);
        car_passed = 0;

        // Timeout with no car
        sensor_exit = 1;
        tick("to_open", S_OUT, 7);
        sensor_exit = 0;
        for (int i = 1; i < 16; i++) tick($sformatf("to_hold%0d", i), S_OUT, 7);
        tick("to_close", S_IDLE, 7);

        // car_passed on the final open cycle still counts
        sensor_exit = 1;
        tick("tl_open", S_OUT, 7);
        sensor_exit = 0;
        for (int i = 1; i < 16; i++) tick($sformatf("tl_hold%0d", i), S_OUT, 7);
        car_passed = 1;
        tick("tl_last_pass", S_IDLE, 6);
        tick("stray_car", S_IDLE, 6);
        car_passed = 0;

        // Reset during OPEN_OUT
        sensor_exit = 1;
        tick("rs_open1", S_OUT, 6);
        car_passed = 1; sensor_exit = 0;
        tick("rs_pass1", S_IDLE, 5);
        car_passed = 0; sensor_exit = 1;
        tick("rs_open2", S_OUT, 5);
        reset = 1;
        tick("rs_reset", S_IDLE, 0);
        reset = 0;
        tick("rs_exit_empty", S_IDLE, 0);
        sensor_exit = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
